dbus_interconnect: RTL

Parametrised single-master data-bus interconnect for the display processor subsystem. It routes core data-bus reads and writes to NUM_SLAVES address-windowed targets such as main memory, I/O registers, palette and framebuffer. Read data is returned from the correct slave after that slave's configured read latency. It also provides per-slave back-pressure, stalls on read-return collisions, and reports unmapped accesses.

---
 rtl/dbus_pkg.sv | 23 ++
 rtl/dbus_rd_tracker.sv | 52 +++++
 rtl/dbus_interconnect.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared types and constants for the data-bus interconnect
// Holds the slave-index width, the read-return slot type and the error
// counter width used by dbus_interconnect and dbus_rd_tracker.
package dbus_pkg;

  // Index width is sized for the largest supported slave count (8) plus the
  // "no slave" code, so one slot type serves every NUM_SLAVES setting.
  localparam int MAX_SLAVES = 8;
  localparam int IDX_W      = $clog2(MAX_SLAVES + 1);
  localparam int LAT_W      = 8;
  localparam int ERR_CNT_W  = 16;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rd_slot_t;

  // The "no slave selected" code equals the slave count.
  function automatic logic [IDX_W-1:0] sel_none(input int num_slaves);
    return IDX_W'(num_slaves);
  endfunction

endpackage

// File: rtl/dbus_rd_tracker.sv
// rtl/dbus_rd_tracker.sv - read-return slot pipeline with collision check
// Ports: clk, reset (sync, active-high); load/lat/idx register an accepted
// read returning after lat cycles; collide flags that the slot a read of
// latency lat would need is already taken; ret_valid/ret_idx expose slot 0.
module dbus_rd_tracker
  import dbus_pkg::*;
#(
  parameter int MAX_RD_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  input  logic [IDX_W-1:0] idx,
  output logic             collide,
  output logic             ret_valid,
  output logic [IDX_W-1:0] ret_idx
);

  rd_slot_t slot_q [MAX_RD_LAT];
  rd_slot_t slot_d [MAX_RD_LAT];

  always_comb begin
    // Slot lat shifts into slot lat-1 on this edge, exactly where a new read
    // of latency lat would be loaded.
    collide = 1'b0;
    for (int i = 1; i < MAX_RD_LAT; i++) begin
      if (LAT_W'(i) == lat) collide = slot_q[i].valid;
    end

    for (int i = 0; i < MAX_RD_LAT - 1; i++) slot_d[i] = slot_q[i+1];
    slot_d[MAX_RD_LAT-1] = '0;

    for (int i = 0; i < MAX_RD_LAT; i++) begin
      if (load && !collide && LAT_W'(i + 1) == lat) begin
        slot_d[i] = rd_slot_t'{valid: 1'b1, idx: idx};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_RD_LAT; i++) slot_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign ret_valid = slot_q[0].valid;
  assign ret_idx   = slot_q[0].idx;

endmodule

// File: rtl/dbus_interconnect.sv
// rtl/dbus_interconnect.sv - single-master address-windowed data-bus interconnect
// Ports: clk, reset (sync, active-high); master m_addr/m_rd_en/m_wr_data/
// m_wr_en in, m_stall/m_rd_data/m_rd_valid/m_err out; err_count/err_addr
// report unmapped accesses; per-slave s_addr/s_rd_en/s_wr_data/s_wr_en out,
// s_rd_data/s_ready in (flattened, slave k in slice k).
module dbus_interconnect
  import dbus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_RD_LAT = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter logic [NUM_SLAVES*LAT_W-1:0] SLV_RD_LAT = {8'd2, 8'd1, 8'd3, 8'd1}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              m_addr,
  input  logic                           m_rd_en,
  input  logic [DATA_W-1:0]              m_wr_data,
  input  logic [DATA_W/8-1:0]            m_wr_en,
  output logic                           m_stall,
  output logic [DATA_W-1:0]              m_rd_data,
  output logic                           m_rd_valid,
  output logic                           m_err,
  output logic [ERR_CNT_W-1:0]           err_count,
  output logic [ADDR_W-1:0]              err_addr,
  output logic [NUM_SLAVES*ADDR_W-1:0]   s_addr,
  output logic [NUM_SLAVES-1:0]          s_rd_en,
  output logic [NUM_SLAVES*DATA_W-1:0]   s_wr_data,
  output logic [NUM_SLAVES*DATA_W/8-1:0] s_wr_en,
  input  logic [NUM_SLAVES*DATA_W-1:0]   s_rd_data,
  input  logic [NUM_SLAVES-1:0]          s_ready
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [IDX_W-1:0] SEL_NONE = sel_none(NUM_SLAVES);

  logic [IDX_W-1:0]     sel;
  logic                 sel_ready;
  logic [LAT_W-1:0]     sel_lat;
  logic                 active, mapped, accept, collide;
  logic                 ret_valid;
  logic [IDX_W-1:0]     ret_idx;

  logic                 m_rd_valid_q, m_rd_valid_d;
  logic [DATA_W-1:0]    m_rd_data_q, m_rd_data_d;
  logic                 m_err_q, m_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;

  // Decode: scan high to low so the lowest matching index wins on overlap.
  // Unmapped accesses behave as an always-ready latency-1 target.
  always_comb begin
    sel = SEL_NONE;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((m_addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
        sel = IDX_W'(k);
      end
    end
    sel_ready = 1'b1;
    sel_lat   = LAT_W'(1);
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel == IDX_W'(k)) begin
        sel_ready = s_ready[k];
        sel_lat   = SLV_RD_LAT[k*LAT_W +: LAT_W];
      end
    end
  end

  assign active  = m_rd_en || (m_wr_en != '0);
  assign mapped  = (sel != SEL_NONE);
  assign m_stall = active && mapped && (!sel_ready || (m_rd_en && collide));
  assign accept  = active && !m_stall;

  dbus_rd_tracker #(
    .MAX_RD_LAT (MAX_RD_LAT)
  ) u_rd_tracker (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && m_rd_en),
    .lat       (sel_lat),
    .idx       (sel),
    .collide   (collide),
    .ret_valid (ret_valid),
    .ret_idx   (ret_idx)
  );

  always_comb begin
    s_addr    = '0;
    s_wr_data = '0;
    s_wr_en   = '0;
    s_rd_en   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (active && sel == IDX_W'(k)) begin
        s_addr[k*ADDR_W +: ADDR_W]    = m_addr;
        s_wr_data[k*DATA_W +: DATA_W] = m_wr_data;
        if (!m_stall) s_wr_en[k*STRB_W +: STRB_W] = m_wr_en;
        s_rd_en[k] = accept && m_rd_en;
      end
    end
  end

  // Slot 0 names the slave whose data is valid this cycle; unmapped reads
  // carry SEL_NONE and so return zero.
  always_comb begin
    m_rd_valid_d = ret_valid;
    m_rd_data_d  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (ret_valid && ret_idx == IDX_W'(k)) m_rd_data_d = s_rd_data[k*DATA_W +: DATA_W];
    end
    m_err_d     = accept && !mapped;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (m_err_d) begin
      err_addr_d = m_addr;
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_rd_valid_q <= 1'b0;
      m_rd_data_q  <= '0;
      m_err_q      <= 1'b0;
      err_count_q  <= '0;
      err_addr_q   <= '0;
    end else begin
      m_rd_valid_q <= m_rd_valid_d;
      m_rd_data_q  <= m_rd_data_d;
      m_err_q      <= m_err_d;
      err_count_q  <= err_count_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign m_rd_valid = m_rd_valid_q;
  assign m_rd_data  = m_rd_data_q;
  assign m_err      = m_err_q;
  assign err_count  = err_count_q;
  assign err_addr   = err_addr_q;

endmodule
